// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4 write master: turns one (address, length) command plus a
// valid/ready beat stream into one INCR burst and reports the write response.
module axi4_write_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  localparam int         NB   = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_AW, S_W, S_B, S_RSP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  beat_cnt;
  logic [1:0]  resp_q;
  logic        cmd_fire, cmd_bad, w_fire, b_fire;

  // The boundary sum is held at 13 bits so that exactly 4096 (legal) is distinguishable.
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len);
    logic [12:0] bytes;
    bytes = ({5'd0, len} + 13'd1) << SIZE;
    return ({1'b0, off} + bytes) > 13'd4096;
  endfunction

  function automatic logic misaligned(input logic [2:0] low);
    return (low & 3'(NB - 1)) != 3'd0;
  endfunction

  assign AWSIZE   = SIZE;
  assign AWBURST  = 2'b01;
  assign WSTRB    = '1;
  assign WDATA    = wr_data;
  assign rsp_resp = resp_q;
  assign cmd_bad  = misaligned(cmd_addr[2:0]) || crosses_4k(cmd_addr[11:0], cmd_len);

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    AWVALID       = 1'b0;
    WVALID        = 1'b0;
    WLAST         = 1'b0;
    wr_data_ready = 1'b0;
    BREADY        = 1'b0;
    rsp_valid     = 1'b0;
    if (!ARESET) begin
      case (state)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) state_nxt = cmd_bad ? S_ERR : S_AW;
        end
        S_ERR: begin
          rsp_valid = 1'b1;
          state_nxt = S_IDLE;
        end
        S_AW: begin
          AWVALID = 1'b1;
          if (AWREADY) state_nxt = S_W;
        end
        S_W: begin
          WVALID        = wr_data_valid;
          wr_data_ready = WREADY;
          WLAST         = (beat_cnt == AWLEN);
          if (wr_data_valid && WREADY && WLAST) state_nxt = S_B;
        end
        S_B: begin
          BREADY = 1'b1;
          if (BVALID) state_nxt = S_RSP;
        end
        S_RSP: begin
          rsp_valid = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign cmd_fire = cmd_valid && cmd_ready;
  assign w_fire   = WVALID && WREADY;
  assign b_fire   = BVALID && BREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      beat_cnt <= 8'd0;
      AWADDR   <= '0;
      AWLEN    <= 8'd0;
      resp_q   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        AWADDR   <= cmd_addr;
        AWLEN    <= cmd_len;
        beat_cnt <= 8'd0;
        if (cmd_bad) resp_q <= 2'b10;
      end
      if (w_fire) beat_cnt <= beat_cnt + 8'd1;
      if (b_fire) resp_q <= BRESP;
    end
  end

endmodule

// File: tb/tb_axi4_write_master.sv
// Bench for axi4_write_master: table of commands driven against a scripted slave,
// beat data checked through an expected-data queue, plus a mid-burst reset sequence.
module tb_axi4_write_master;

  localparam int AW_W = 16;
  localparam int DW   = 32;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic            cmd_valid, cmd_ready;
  logic [AW_W-1:0] cmd_addr;
  logic [7:0]      cmd_len;
  logic [DW-1:0]   wr_data;
  logic            wr_data_valid, wr_data_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_resp;
  logic [AW_W-1:0] AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID, AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST, WVALID, WREADY;
  logic [1:0]      BRESP;
  logic            BVALID, BREADY;

  axi4_write_master #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          aw_stall;
    bit          w_alt;
    logic [1:0]  bresp;
    bit          exp_err;
    logic [1:0]  exp_resp;
    bit          chk_lat;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_q[$];

  task automatic idle_inputs();
    cmd_valid     = 1'b0;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    AWREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    BRESP         = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, aw_cycles, beats, last_cyc, bready_cyc, w_early;
    bit aw_done, got_rsp;
    logic [31:0] exp_d;
    cyc = 0; aw_cycles = 0; beats = 0; last_cyc = -1; bready_cyc = -1; w_early = 0;
    aw_done = 1'b0; got_rsp = 1'b0;
    if (!v.exp_err)
      for (int i = 0; i <= int'(v.len); i++) exp_q.push_back(v.base + 32'(i));
    @(negedge ACLK);
    idle_inputs();
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    #1;
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    while (!got_rsp && cyc < 60) begin
      @(negedge ACLK);
      cyc++;
      cmd_valid     = 1'b0;
      AWREADY       = (aw_cycles >= v.aw_stall);
      WREADY        = v.w_alt ? cyc[0] : 1'b1;
      wr_data_valid = 1'b1;
      wr_data       = v.base + 32'(beats);
      BVALID        = 1'b1;
      BRESP         = v.bresp;
      #1;
      if (AWVALID) begin
        aw_cycles++;
        if (aw_cycles == 1) begin
          chk({tag, " awvalid_rise_cycle"}, 64'(cyc), 1);
          chk({tag, " awsize"}, AWSIZE, 2);
          chk({tag, " awburst"}, AWBURST, 1);
        end
        chk({tag, " awaddr"}, AWADDR, v.addr);
        chk({tag, " awlen"}, AWLEN, v.len);
      end
      if (WVALID && !aw_done) w_early++;
      if (WVALID && WREADY) begin
        beats++;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        chk({tag, " wdata"}, WDATA, exp_d);
        chk({tag, " wlast"}, WLAST, exp_q.size() == 0);
        last_cyc = cyc;
      end
      if (BREADY && bready_cyc < 0) bready_cyc = cyc;
      if (rsp_valid) begin
        got_rsp = 1'b1;
        chk({tag, " rsp_resp"}, rsp_resp, v.exp_resp);
        if (v.exp_err)      chk({tag, " err_latency"}, 64'(cyc), 1);
        else if (v.chk_lat) chk({tag, " rsp_latency"}, 64'(cyc), 64'(int'(v.len) + 4));
      end
      if (AWVALID && AWREADY) aw_done = 1'b1;
    end
    chk({tag, " rsp_seen_within_budget"}, got_rsp, 1);
    chk({tag, " aw_cycles"}, 64'(aw_cycles), v.exp_err ? 0 : 64'(v.aw_stall + 1));
    chk({tag, " beats"}, 64'(beats), v.exp_err ? 0 : 64'(int'(v.len) + 1));
    chk({tag, " w_before_aw"}, 64'(w_early), 0);
    if (!v.exp_err) chk({tag, " bready_rise"}, 64'(bready_cyc), 64'(last_cyc + 1));
    exp_q.delete();
    @(negedge ACLK);
    idle_inputs();
    #1;
    chk({tag, " rsp_one_cycle"}, rsp_valid, 0);
    chk({tag, " back_to_idle"}, cmd_ready, 1);
  endtask

  initial begin
    int beats;
    //        addr     len    base          stall alt bresp  err exp   lat
    vecs[0] = '{16'h0010, 8'd0, 32'hDEADBEEF, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[1] = '{16'h0100, 8'd3, 32'h00000001, 0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[2] = '{16'h0200, 8'd1, 32'hA5A50000, 5, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[3] = '{16'h0FF8, 8'd3, 32'h0,        0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0};
    vecs[4] = '{16'h0002, 8'd0, 32'h0,        0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0};
    vecs[5] = '{16'h0040, 8'd2, 32'h12340000, 0, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1};
    vecs[6] = '{16'h0FF0, 8'd3, 32'h55AA0000, 0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1};

    ARESET   = 1'b1;
    cmd_addr = '0;
    cmd_len  = '0;
    idle_inputs();
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset awvalid", AWVALID, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset awaddr", AWADDR, 0);
    chk("reset awlen", AWLEN, 0);
    chk("reset rsp_resp", rsp_resp, 0);
    chk("wstrb", WSTRB, 4'hF);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("post-reset cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 4-beat burst after two beats have moved.
    @(negedge ACLK);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0300;
    cmd_len   = 8'd3;
    beats     = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge ACLK);
      cmd_valid     = 1'b0;
      AWREADY       = 1'b1;
      WREADY        = 1'b1;
      wr_data_valid = 1'b1;
      wr_data       = 32'h100 + 32'(beats);
      #1;
      if (WVALID && WREADY) beats++;
    end
    chk("midrst beats_before_reset", 64'(beats), 2);
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    #1;
    chk("midrst awvalid", AWVALID, 0);
    chk("midrst wvalid", WVALID, 0);
    chk("midrst bready", BREADY, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst cmd_ready", cmd_ready, 0);
    chk("midrst awaddr", AWADDR, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    idle_inputs();
    #1;
    chk("midrst cmd_ready_after", cmd_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      #1;
      chk("midrst no_rsp", rsp_valid, 0);
    end
    run_vec(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
